// File: rtl/ulaplus_pal_pkg.sv
// rtl/ulaplus_pal_pkg.sv - shared types and constants for the ULAplus palette controller
//
// Purpose: register-group encoding of addr_reg[7:6] and the default I/O port
//          addresses used as parameter defaults by ulaplus_pal.
// Ports:   none (package).
package ulaplus_pal_pkg;

  typedef enum logic [1:0] {
    GRP_PALETTE = 2'b00,
    GRP_MODE    = 2'b01
  } ulaplus_group_t;

  localparam logic [15:0] ULAPLUS_PORT_REG  = 16'hBF3B;
  localparam logic [15:0] ULAPLUS_PORT_DATA = 16'hFF3B;

endpackage

// File: rtl/ulaplus_pal_wfifo.sv
// rtl/ulaplus_pal_wfifo.sv - synchronous valid/ready write FIFO for palette updates
//
// Purpose: buffers palette writes towards the palette RAM arbiter.
// Ports:   clk28, rst_n (async, active-low)
//          push/data_in/full  - write side (push while full is refused unless a pop
//                               happens in the same cycle)
//          valid/ready/data_out - read side; head is stable while valid && !ready
module ulaplus_wfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk28,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data_out
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop;
  logic             wr_en;

  always_comb begin
    valid    = (wr_ptr_q != rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop      = valid && ready;
    // A pop in the same cycle frees the slot the push needs.
    wr_en    = push && (!full || pop);
    wr_ptr_d = wr_en ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
    data_out = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk28) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_in;
    end
  end

endmodule

// File: rtl/ulaplus_pal.sv
// rtl/ulaplus_pal.sv - ULAplus port decoder, palette shadow and palette write forwarder
//
// Purpose: decodes the ULAplus register/data ports, keeps a readable shadow of the
//          palette, holds the mode bits and forwards palette writes through a FIFO.
// Optional: ULAPLUS_AUTOINC_EN - palette index auto-increments after data accesses.
// Ports:   clk28, rst_n (async, active-low), en (block enable)
//          ioreq, a, d, rd, wr   - CPU I/O bus (levels held for the whole access)
//          d_out, d_out_active   - registered read data and bus-drive enable
//          active, grey          - video path controls
//          pal_wr_valid/addr/data/ready - palette write stream to the arbiter
//          pal_ovf               - sticky: a palette write was dropped (FIFO full)
module ulaplus_pal
  import ulaplus_pal_pkg::*;
#(
  parameter int          ENTRIES    = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] PORT_REG   = ULAPLUS_PORT_REG,
  parameter logic [15:0] PORT_DATA  = ULAPLUS_PORT_DATA,
  localparam int         IDX_W      = $clog2(ENTRIES)
) (
  input  logic             clk28,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ioreq,
  input  logic [15:0]      a,
  input  logic [7:0]       d,
  input  logic             rd,
  input  logic             wr,
  output logic [7:0]       d_out,
  output logic             d_out_active,
  output logic             active,
  output logic             grey,
  output logic             pal_wr_valid,
  output logic [IDX_W-1:0] pal_wr_addr,
  output logic [7:0]       pal_wr_data,
  input  logic             pal_wr_ready,
  output logic             pal_ovf
);

  logic [7:0]       addr_q, addr_d;
  logic             active_q, active_d;
  logic             grey_q, grey_d;
  logic             ovf_q, ovf_d;
  logic             reg_wr_prev_q, reg_wr_prev_d;
  logic             data_wr_prev_q, data_wr_prev_d;
  logic             d_out_active_q, d_out_active_d;
  logic [7:0]       d_out_q, d_out_d;
`ifdef ULAPLUS_AUTOINC_EN
  logic             inc_pend_q, inc_pend_d;
  logic             rd_end;
`endif

  logic [7:0]       shadow_q [ENTRIES];
  logic             cs_reg, cs_data, rd_now;
  logic             reg_wr_stb, data_wr_stb;
  logic             is_pal, is_mode_grp, mode_sel;
  logic [IDX_W-1:0] idx;
  logic [7:0]       rd_mux;
  logic             push, fifo_full;

  always_comb begin
    cs_reg         = en && ioreq && (a == PORT_REG);
    cs_data        = en && ioreq && (a == PORT_DATA);
    reg_wr_prev_d  = cs_reg && wr;
    data_wr_prev_d = cs_data && wr;
    // Rising-edge detect on the decoded condition: a held wr acts once.
    reg_wr_stb     = reg_wr_prev_d && !reg_wr_prev_q;
    data_wr_stb    = data_wr_prev_d && !data_wr_prev_q;
    rd_now         = cs_data && rd;

    idx         = addr_q[IDX_W-1:0];
    is_pal      = (addr_q[7:6] == GRP_PALETTE);
    is_mode_grp = (addr_q[7:6] == GRP_MODE);
    mode_sel    = is_mode_grp && (addr_q[5:0] == 6'd0);
    push        = data_wr_stb && is_pal;

    rd_mux = 8'h00;
    if (is_pal) begin
      rd_mux = shadow_q[idx];
    end else if (is_mode_grp) begin
      rd_mux = {6'b0, grey_q, active_q};
    end

    d_out_active_d = rd_now;
    d_out_d        = rd_now ? rd_mux : 8'h00;

    active_d = active_q;
    grey_d   = grey_q;
    if (!en) begin
      active_d = 1'b0;
      grey_d   = 1'b0;
    end else if (data_wr_stb && mode_sel) begin
      active_d = d[0];
      grey_d   = d[1];
    end

    // Overflow only when the push really loses its slot (no same-cycle pop).
    ovf_d = ovf_q || (push && fifo_full && !(pal_wr_valid && pal_wr_ready));

    addr_d = addr_q;
`ifdef ULAPLUS_AUTOINC_EN
    // d_out_active_q is the registered read condition, so it doubles as rd history.
    rd_end     = d_out_active_q && !rd_now;
    inc_pend_d = push;
    if (inc_pend_q || (rd_end && is_pal)) begin
      addr_d[IDX_W-1:0] = idx + {{(IDX_W-1){1'b0}}, 1'b1};
    end
`endif
    if (reg_wr_stb) begin
      addr_d = d;
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      addr_q         <= 8'h00;
      active_q       <= 1'b0;
      grey_q         <= 1'b0;
      ovf_q          <= 1'b0;
      reg_wr_prev_q  <= 1'b0;
      data_wr_prev_q <= 1'b0;
      d_out_active_q <= 1'b0;
      d_out_q        <= 8'h00;
`ifdef ULAPLUS_AUTOINC_EN
      inc_pend_q     <= 1'b0;
`endif
    end else begin
      addr_q         <= addr_d;
      active_q       <= active_d;
      grey_q         <= grey_d;
      ovf_q          <= ovf_d;
      reg_wr_prev_q  <= reg_wr_prev_d;
      data_wr_prev_q <= data_wr_prev_d;
      d_out_active_q <= d_out_active_d;
      d_out_q        <= d_out_d;
`ifdef ULAPLUS_AUTOINC_EN
      inc_pend_q     <= inc_pend_d;
`endif
    end
  end

  // Shadow palette has no reset; it is written even when the FIFO drops the entry.
  always_ff @(posedge clk28) begin
    if (push) begin
      shadow_q[idx] <= d;
    end
  end

  ulaplus_wfifo #(
    .WIDTH (IDX_W + 8),
    .DEPTH (FIFO_DEPTH)
  ) u_wfifo (
    .clk28    (clk28),
    .rst_n    (rst_n),
    .push     (push),
    .data_in  ({idx, d}),
    .full     (fifo_full),
    .valid    (pal_wr_valid),
    .ready    (pal_wr_ready),
    .data_out ({pal_wr_addr, pal_wr_data})
  );

  assign d_out        = d_out_q;
  assign d_out_active = d_out_active_q;
  assign active       = active_q;
  assign grey         = grey_q;
  assign pal_ovf      = ovf_q;

endmodule

// File: tb/tb_ulaplus_pal.sv
// tb/tb_ulaplus_pal.sv - directed self-checking bench for ulaplus_pal
module tb_ulaplus_pal;

  logic        clk28 = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        ioreq = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [7:0]  d = 8'h00;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  d_out;
  logic        d_out_active;
  logic        active;
  logic        grey;
  logic        pal_wr_valid;
  logic [5:0]  pal_wr_addr;
  logic [7:0]  pal_wr_data;
  logic        pal_wr_ready = 1'b0;
  logic        pal_ovf;

  int vectors = 0;
  int miscompares = 0;
  logic [13:0] xfers[$];
  logic [7:0]  rdata;

  localparam logic [15:0] P_REG  = 16'hBF3B;
  localparam logic [15:0] P_DATA = 16'hFF3B;

  always #5 clk28 = ~clk28;

  ulaplus_pal dut (
    .clk28        (clk28),
    .rst_n        (rst_n),
    .en           (en),
    .ioreq        (ioreq),
    .a            (a),
    .d            (d),
    .rd           (rd),
    .wr           (wr),
    .d_out        (d_out),
    .d_out_active (d_out_active),
    .active       (active),
    .grey         (grey),
    .pal_wr_valid (pal_wr_valid),
    .pal_wr_addr  (pal_wr_addr),
    .pal_wr_data  (pal_wr_data),
    .pal_wr_ready (pal_wr_ready),
    .pal_ovf      (pal_ovf)
  );

  // Inputs only change 1 time unit after posedge, so a negedge sample predicts the transfer.
  always @(negedge clk28) begin
    if (rst_n && pal_wr_valid && pal_wr_ready) xfers.push_back({pal_wr_addr, pal_wr_data});
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic io_write(input logic [15:0] addr, input logic [7:0] data);
    ioreq = 1'b1; a = addr; d = data; wr = 1'b1;
    repeat (3) @(posedge clk28);
    #1;
    wr = 1'b0; ioreq = 1'b0;
    @(posedge clk28);
    #1;
  endtask

  task automatic io_read(input logic [15:0] addr, input logic exp_act, output logic [7:0] data);
    ioreq = 1'b1; a = addr; rd = 1'b1;
    @(posedge clk28);
    #1;
    check("rd_active_on", {15'b0, d_out_active}, {15'b0, exp_act});
    data = d_out;
    @(posedge clk28);
    #1;
    rd = 1'b0; ioreq = 1'b0;
    @(posedge clk28);
    #1;
    check("rd_active_off", {15'b0, d_out_active}, 16'h0000);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk28);
    #1;
    check("rst_active", {15'b0, active}, 16'h0);
    check("rst_grey", {15'b0, grey}, 16'h0);
    check("rst_dout_act", {15'b0, d_out_active}, 16'h0);
    check("rst_dout", {8'b0, d_out}, 16'h0);
    check("rst_valid", {15'b0, pal_wr_valid}, 16'h0);
    check("rst_ovf", {15'b0, pal_ovf}, 16'h0);
    rst_n = 1'b1; en = 1'b1; pal_wr_ready = 1'b1;
    @(posedge clk28);
    #1;

    // Mode register
    io_write(P_REG, 8'h40);
    io_write(P_DATA, 8'h03);
    check("mode_active", {15'b0, active}, 16'h1);
    check("mode_grey", {15'b0, grey}, 16'h1);
    io_read(P_DATA, 1'b1, rdata);
    check("mode_read", {8'b0, rdata}, 16'h0003);
    check("mode_no_push", 16'(xfers.size()), 16'd0);
    check("mode_no_valid", {15'b0, pal_wr_valid}, 16'h0);

    // Single palette write, held wr, E+1 latency
    io_write(P_REG, 8'h05);
    ioreq = 1'b1; a = P_DATA; d = 8'hE0; wr = 1'b1;
    @(posedge clk28);
    #1;
    check("e1_valid", {15'b0, pal_wr_valid}, 16'h1);
    check("e1_head", {2'b0, pal_wr_addr, pal_wr_data}, {2'b0, 6'd5, 8'hE0});
    @(posedge clk28);
    #1;
    check("e2_valid_low", {15'b0, pal_wr_valid}, 16'h0);
    repeat (3) @(posedge clk28);
    #1;
    wr = 1'b0; ioreq = 1'b0;
    @(posedge clk28);
    #1;
    check("held_wr_one_push", 16'(xfers.size()), 16'd1);
    if (xfers.size() > 0) check("xfer_05", {2'b0, xfers[0]}, {2'b0, 6'd5, 8'hE0});
    io_write(P_REG, 8'h05);
    io_read(P_DATA, 1'b1, rdata);
    check("read_E0", {8'b0, rdata}, 16'h00E0);

    // Overflow: five writes into a 4-deep FIFO with the arbiter stalled
    pal_wr_ready = 1'b0;
    xfers.delete();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("ovf_before_5th", {15'b0, pal_ovf}, 16'h0);
      io_write(P_REG, 8'h10 + 8'(i));
      io_write(P_DATA, 8'hA0 + 8'(i));
    end
    check("ovf_set", {15'b0, pal_ovf}, 16'h1);
    check("ovf_valid", {15'b0, pal_wr_valid}, 16'h1);
    check("ovf_head_stable", {2'b0, pal_wr_addr, pal_wr_data}, {2'b0, 6'd16, 8'hA0});
    check("ovf_no_xfer", 16'(xfers.size()), 16'd0);
    for (int i = 0; i < 5; i++) begin
      io_write(P_REG, 8'h10 + 8'(i));
      io_read(P_DATA, 1'b1, rdata);
      check("ovf_shadow", {8'b0, rdata}, {8'b0, 8'hA0 + 8'(i)});
    end
    pal_wr_ready = 1'b1;
    repeat (8) @(posedge clk28);
    #1;
    check("drain_count", 16'(xfers.size()), 16'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < xfers.size()) check("drain_order", {2'b0, xfers[i]}, {2'b0, 6'd16 + 6'(i), 8'hA0 + 8'(i)});
    end
    check("ovf_sticky", {15'b0, pal_ovf}, 16'h1);

    // Auto-increment wrap (or its absence)
    xfers.delete();
    io_write(P_REG, 8'h3F);
    io_write(P_DATA, 8'hAA);
    io_write(P_DATA, 8'hBB);
    io_write(P_DATA, 8'hCC);
    repeat (2) @(posedge clk28);
    #1;
    check("ai_xfer_count", 16'(xfers.size()), 16'd3);
    io_write(P_REG, 8'h3F);
    io_read(P_DATA, 1'b1, rdata);
`ifdef ULAPLUS_AUTOINC_EN
    check("ai_shadow63", {8'b0, rdata}, 16'h00AA);
    if (xfers.size() > 1) check("ai_xfer1", {2'b0, xfers[1]}, {2'b0, 6'd0, 8'hBB});
    io_write(P_REG, 8'h00);
    io_read(P_DATA, 1'b1, rdata);
    check("ai_shadow0", {8'b0, rdata}, 16'h00BB);
    io_write(P_REG, 8'h01);
    io_read(P_DATA, 1'b1, rdata);
    check("ai_shadow1", {8'b0, rdata}, 16'h00CC);
`else
    check("noai_shadow63", {8'b0, rdata}, 16'h00CC);
    if (xfers.size() > 1) check("noai_xfer1", {2'b0, xfers[1]}, {2'b0, 6'd63, 8'hBB});
`endif

    // Enable dropped mid-session
    io_write(P_REG, 8'h22);
    io_write(P_DATA, 8'h5A);
    io_write(P_REG, 8'h40);
    io_write(P_DATA, 8'h03);
    check("en_pre_active", {15'b0, active}, 16'h1);
    pal_wr_ready = 1'b0;
    xfers.delete();
    io_write(P_REG, 8'h07);
    io_write(P_DATA, 8'h77);
    io_write(P_REG, 8'h40);
    check("en_pending", {15'b0, pal_wr_valid}, 16'h1);
    en = 1'b0;
    @(posedge clk28);
    #1;
    check("en_off_active", {15'b0, active}, 16'h0);
    check("en_off_grey", {15'b0, grey}, 16'h0);
    io_write(P_REG, 8'h22);
    io_write(P_DATA, 8'h55);
    check("en_off_ignored", {15'b0, active}, 16'h0);
    io_read(P_DATA, 1'b0, rdata);
    pal_wr_ready = 1'b1;
    repeat (4) @(posedge clk28);
    #1;
    check("en_off_drain", 16'(xfers.size()), 16'd1);
    if (xfers.size() > 0) check("en_off_xfer", {2'b0, xfers[0]}, {2'b0, 6'd7, 8'h77});
    check("en_off_empty", {15'b0, pal_wr_valid}, 16'h0);
    en = 1'b1;
    @(posedge clk28);
    #1;
    io_read(P_DATA, 1'b1, rdata);
    check("en_addr_held", {8'b0, rdata}, 16'h0000);

    // Reset with entries pending
    io_write(P_DATA, 8'h03);
    pal_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      io_write(P_REG, 8'h1E + 8'(i));
      io_write(P_DATA, 8'h30 + 8'(i));
    end
    check("rst2_pending", {15'b0, pal_wr_valid}, 16'h1);
    check("rst2_pre_active", {15'b0, active}, 16'h1);
    @(posedge clk28);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst2_valid", {15'b0, pal_wr_valid}, 16'h0);
    check("rst2_ovf", {15'b0, pal_ovf}, 16'h0);
    check("rst2_active", {15'b0, active}, 16'h0);
    check("rst2_grey", {15'b0, grey}, 16'h0);
    repeat (2) @(posedge clk28);
    #1;
    rst_n = 1'b1;
    @(posedge clk28);
    #1;
    check("rst2_after", {15'b0, pal_wr_valid}, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ulaplus_pal.md
# ulaplus_pal

Second-generation ULAplus controller: decodes the register and data ports and holds a readable shadow copy of the palette. It also forwards every palette write to the palette RAM arbiter through a small valid/ready write FIFO. It sits beside the ULA on the CPU I/O bus and drives the video path's palette-enable and greyscale controls.

## Interface
- ENTRIES, 64: palette entries. Power of 2, 16..64. IDX_W = $clog2(ENTRIES).
- FIFO_DEPTH, 4: write FIFO depth. Power of 2, ≥2.
- PORT_REG, 16'hBF3B: register-select port address.
- PORT_DATA, 16'hFF3B: data port address.

Ports:
- rst_n  in  1  reset: asynchronous, active-low.
- clk28  in  1  clock, 28 MHz.
- en  in  1  block enable. Low: ports not decoded, active/grey forced 0.
- bus  cpu_bus  —  CPU bus; uses ioreq, a[15:0], d[7:0], rd, wr (level, held for the whole access).
- d_out  out  8  read data.
- d_out_active  out  1  d_out drives the bus.
- active  out  1  ULAplus palette mode on.
- grey  out  1  greyscale mode.
- pal_wr_valid  out  1  FIFO head valid.
- pal_wr_addr  out  IDX_W  FIFO head palette index.
- pal_wr_data  out  8  FIFO head colour (GGGRRRBB).
- pal_wr_ready  in  1  arbiter accepts the head.
- pal_ovf  out  1  sticky: a palette write was dropped because the FIFO was full.

## Operation
- cs_reg = en && ioreq && a==PORT_REG. cs_data = en && ioreq && a==PORT_DATA.
- Strobes are taken from registered history of the conditions, so each access acts exactly once:
  - wr_stb = (cs && wr) && !prev.
  - rd_end = prev_rd && !(cs_data && rd).
- addr_reg[7:0]: loaded from d on a PORT_REG wr_stb.
  - group = addr_reg[7:6]; idx = addr_reg[IDX_W-1:0].
  - Index bits above IDX_W are ignored.
- PORT_DATA write, by group:
  - 00 (palette): shadow[idx] <= d; push {idx, d} into the FIFO.
  - 01 with addr_reg[5:0]==0 (mode): active <= d[0], grey <= d[1]. No FIFO push.
  - Any other group/index: ignored.
- PORT_DATA read data (d_out), by group:
  - 00: shadow[idx].
  - 01: {6'b0, grey, active}.
  - Otherwise: 8'h00.
- PORT_REG is write-only; reads are not answered.
- FIFO push rules:
  - Push while full with no pop in the same cycle: entry dropped, pal_ovf <= 1. The shadow is still updated.
  - Push and pop in the same cycle while full: both happen, no overflow.
- Head transfer occurs when pal_wr_valid && pal_wr_ready. Head addr/data stay stable while valid && !ready.
- en low:
  - active and grey are cleared.
  - addr_reg, shadow and pal_ovf are held.
  - The FIFO keeps draining.
- Reset values:
  - active, grey, d_out_active, pal_wr_valid, pal_ovf, addr_reg, d_out: all 0.
  - FIFO empty.
  - Shadow has no reset; reading an unwritten entry returns an unspecified value.

## Timing
- Edge E = first clk28 edge that samples cs && wr high.
  - At E: addr_reg, shadow, mode bits and the FIFO update.
  - E+1: pal_wr_valid high, if the FIFO was empty.
- Read: d_out_active and d_out are registered from cs_data && rd. Both go high one clk28 after rd is first sampled and drop one clk28 after rd falls.
- d_out is stable for the whole read. A write to shadow[idx] at E is visible to a read that starts at E+1.
- FIFO throughput: one pop per clk28. Latency with the arbiter always ready: entry accepted at E+1, slot free at E+2.
- Reset mid-operation: FIFO contents are lost and valid drops at once; the arbiter must tolerate an abandoned head.

## Configuration
- ULAPLUS_AUTOINC_EN defined: in group 00, idx auto-increments after each data access.
  - After a data write: at the edge following E.
  - After a data read: on rd_end.
  - idx wraps ENTRIES-1 → 0; addr_reg[7:6] and the bits above IDX_W are unchanged.
  - Group 01 never increments.
- Undefined: addr_reg changes only on PORT_REG writes.

## Structure
- Package common gains:
  - ulaplus_group_t (GRP_PALETTE=2'b00, GRP_MODE=2'b01).
  - ULAPLUS_PORT_REG / ULAPLUS_PORT_DATA constants, used as parameter defaults.
- Sub-module ulaplus_wfifo: synchronous FIFO, parametrised by WIDTH and DEPTH. Ports: push/data_in/full, valid/ready/data_out. Overflow detection stays in ulaplus_pal.

## Test plan
- Write BF3B=8'h40 then FF3B=8'h03 → active=1, grey=1. FF3B read returns 8'h03. No pal_wr_valid.
- Write BF3B=8'h05 then FF3B=8'hE0, pal_wr_ready=1 → one transfer {05, E0} at E+1. FF3B read returns E0. A held wr produces exactly one push.
- pal_wr_ready=0, five palette writes with FIFO_DEPTH=4 → entries 1–4 are held in order, the fifth is dropped, pal_ovf=1. All five are in the shadow. Releasing ready drains 4 transfers in order.
- AUTOINC: BF3B=8'h3F, write AA then BB → shadow[63]=AA, shadow[0]=BB, addr_reg=8'h01. Without the macro: shadow[63]=BB.
- Drop en mid-session → active=0 and grey=0 next clk28. Port accesses are ignored, the FIFO still drains. Re-enable: addr_reg is unchanged.
- Assert rst_n low with 3 FIFO entries pending → pal_wr_valid=0 immediately, all flags 0.
